// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//   Multi-cycle adder/subtractor. Each operation is split into NDIG = WIDTH/DIGIT
//   slices that are processed LSB slice first, one per clock. A carry register
//   links each slice to the next. Subtraction is done as a + ~b + ~c_in, so
//   c_out = 1 means "no borrow".
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/mode present
//   in_ready   out  high in IDLE: an operation can be accepted
//   a, b       in   WIDTH-bit operands
//   c_in       in   carry in (add) / borrow in (sub)
//   sub        in   0: a+b+c_in, 1: a-b-c_in
//   out_valid  out  high in DONE: result valid
//   out_ready  in   consumer takes the result
//   sum        out  WIDTH-bit result, modulo 2^WIDTH
//   c_out      out  carry out of bit WIDTH-1
//   overflow   out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("digit_serial_adder: DIGIT must satisfy 1 <= DIGIT <= WIDTH and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One slice as a ripple of full-adder cells. Returns {carry out, carry into
  // the slice MSB, slice sum}; the middle bit feeds the overflow detection.
  function automatic logic [DIGIT+1:0] fa_ripple(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             ci
  );
    logic [DIGIT-1:0] s;
    logic             c;
    logic             c_msb;
    s     = {DIGIT{1'b0}};
    c     = ci;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, c_msb, s};
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;

  logic [31:0]      w_base;
  logic [DIGIT-1:0] w_a_slice;
  logic [DIGIT-1:0] w_b_slice;
  logic [DIGIT-1:0] w_slice_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;

  // Bit offset of the slice being processed; shifts avoid wide select indices.
  assign w_base    = 32'(r_cnt) * 32'(DIGIT);
  assign w_a_slice = DIGIT'(r_a >> w_base);
  assign w_b_slice = DIGIT'(r_b >> w_base);
  assign {w_cout, w_cmsb, w_slice_sum} = fa_ripple(w_a_slice, w_b_slice, r_carry);
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      S_RUN: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
      S_DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture on accept, one slice per RUN edge, flags on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_carry    <= 1'b0;
      r_cnt      <= {CW{1'b0}};
      r_sum      <= {WIDTH{1'b0}};
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~c_in : c_in;
            r_cnt   <= {CW{1'b0}};
          end
        end
        S_RUN: begin
          r_sum   <= (r_sum & ~(SLICE_MASK << w_base)) | (WIDTH'(w_slice_sum) << w_base);
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1'b1);
          if (w_last) begin
            r_c_out    <= w_cout;
            r_overflow <= w_cmsb ^ w_cout;
          end
        end
        S_DONE: begin
          r_carry <= r_carry;
        end
        default: begin
          r_carry <= 1'b0;
        end
      endcase
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;

endmodule
